riscv_dmem_responder: RTL and testbench



---
 rtl/riscv_pkg.sv | 33 +++
 rtl/riscv_dmem_array.sv | 65 ++++++
 rtl/riscv_dmem_responder.sv | 170 +++++++++++++++++
 tb/tb_riscv_dmem_responder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared types for the riscv32i data-memory path.
//   dmem_state_e : responder FSM states (IDLE, WAIT, RESP)
//   dmem_req_t   : one latched data-memory request {we, addr, be, wdata}
//   dmem_rsp_t   : one data-memory response {rdata, err}
//   WORD_BYTES   : byte lanes per 32-bit word
//   DMEM_AW      : width of the address field carried in dmem_req_t
// -----------------------------------------------------------------------------
package riscv_pkg;

    localparam int WORD_BYTES = 4;
    localparam int DMEM_AW    = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    typedef struct packed {
        logic                  we;
        logic [DMEM_AW-1:0]    addr;
        logic [WORD_BYTES-1:0] be;
        logic [31:0]           wdata;
    } dmem_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } dmem_rsp_t;

endpackage

// File: rtl/riscv_dmem_array.sv
// -----------------------------------------------------------------------------
// riscv_dmem_array
// Single-port DEPTH x 32-bit word store with per-byte write enables and a
// registered read port. The read register doubles as the response data
// register: it loads the addressed word on a read, and is cleared on writes,
// errors (clr_i) and reset so that the responder's rdata output is always a
// flop output.
// Ports:
//   clk_i    clock
//   rst_i    synchronous active-high reset (clears read register only)
//   wr_en_i  perform byte-enabled write at addr_i
//   rd_en_i  load mem[addr_i] into the read register
//   clr_i    clear the read register (ignored when rd_en_i is set)
//   addr_i   word index
//   be_i     byte-lane enables for writes
//   wdata_i  write data
//   rdata_o  registered read data
// -----------------------------------------------------------------------------
module riscv_dmem_array
    import riscv_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int IW    = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic                  rd_en_i,
    input  logic                  clr_i,
    input  logic [IW-1:0]         addr_i,
    input  logic [WORD_BYTES-1:0] be_i,
    input  logic [31:0]           wdata_i,
    output logic [31:0]           rdata_o
);

    logic [31:0] mem_r [DEPTH];
    logic [31:0] rdata_r;

    // Byte-lane write port; contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            for (int n = 0; n < WORD_BYTES; n++) begin
                if (be_i[n]) begin
                    mem_r[addr_i][8*n +: 8] <= wdata_i[8*n +: 8];
                end
            end
        end
    end

    // Registered read / response-data register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_r <= 32'h0000_0000;
        end else if (rd_en_i) begin
            rdata_r <= mem_r[addr_i];
        end else if (clr_i) begin
            rdata_r <= 32'h0000_0000;
        end else begin
            rdata_r <= rdata_r;
        end
    end

    assign rdata_o = rdata_r;

endmodule

// File: rtl/riscv_dmem_responder.sv
// -----------------------------------------------------------------------------
// riscv_dmem_responder
// Data-memory responder for the riscv32i load/store path. Accepts one word
// request at a time, waits LATENCY cycles, then performs a byte-enabled write
// or a word read and presents the response under a valid/ready handshake.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   req_valid_i/ready_o   request handshake (ready only in IDLE)
//   req_we_i              1 = write, 0 = read
//   req_addr_i            byte address (AW bits, AW <= 32)
//   req_be_i, req_wdata_i byte enables and data for writes
//   rsp_valid_o/ready_i   response handshake
//   rsp_rdata_o           read data; 0 for writes and errors
//   rsp_err_o             misaligned or out-of-range address
// -----------------------------------------------------------------------------
module riscv_dmem_responder
    import riscv_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2,
    parameter int AW      = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic          req_we_i,
    input  logic [AW-1:0] req_addr_i,
    input  logic [3:0]    req_be_i,
    input  logic [31:0]   req_wdata_i,
    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic [31:0]   rsp_rdata_o,
    output logic          rsp_err_o
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // WAIT is entered with LATENCY-1 so that WAIT lasts exactly LATENCY cycles.
    localparam logic [3:0] LAT_INIT = 4'((LATENCY > 0) ? (LATENCY - 1) : 0);
    localparam logic [DMEM_AW-3:0] DEPTH_WORDS = (DMEM_AW - 2)'(DEPTH);

    dmem_state_e state_r, state_next_s;
    logic [3:0]  cnt_r, cnt_next_s;
    dmem_req_t   req_r, req_next_s;
    dmem_req_t   in_req_s, cur_req_s;
    logic        req_ready_r;
    logic        rsp_valid_r, rsp_valid_next_s;
    logic        rsp_err_r, rsp_err_next_s;
    logic        enter_resp_s;
    logic        cur_err_s;
    logic        arr_wr_en_s, arr_rd_en_s, arr_clr_s;
    logic [31:0] arr_rdata_s;
    dmem_rsp_t   rsp_s;

    // Misaligned or beyond the last word.
    function automatic logic addr_err_f(input logic [DMEM_AW-1:0] a);
        return (a[1:0] != 2'b00) || (a[DMEM_AW-1:2] >= DEPTH_WORDS);
    endfunction

    assign in_req_s.we    = req_we_i;
    assign in_req_s.addr  = DMEM_AW'(req_addr_i);
    assign in_req_s.be    = req_be_i;
    assign in_req_s.wdata = req_wdata_i;

    // Next-state, wait counter and response-entry decode.
    always_comb begin
        state_next_s     = state_r;
        cnt_next_s       = cnt_r;
        req_next_s       = req_r;
        cur_req_s        = req_r;
        enter_resp_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_valid_i && req_ready_r) begin
                    req_next_s = in_req_s;
                    if (LATENCY > 0) begin
                        state_next_s = WAIT;
                        cnt_next_s   = LAT_INIT;
                    end else begin
                        // Zero latency: the access happens on the acceptance edge.
                        state_next_s = RESP;
                        enter_resp_s = 1'b1;
                        cur_req_s    = in_req_s;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_next_s = RESP;
                    enter_resp_s = 1'b1;
                end else begin
                    cnt_next_s = cnt_r - 4'd1;
                end
            end
            RESP: begin
                if (rsp_valid_r && rsp_ready_i) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RESP;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase

        cur_err_s = addr_err_f(cur_req_s.addr);

        if (enter_resp_s) begin
            rsp_valid_next_s = 1'b1;
            rsp_err_next_s   = cur_err_s;
        end else if ((state_r == RESP) && rsp_ready_i) begin
            rsp_valid_next_s = 1'b0;
            rsp_err_next_s   = rsp_err_r;
        end else begin
            rsp_valid_next_s = rsp_valid_r;
            rsp_err_next_s   = rsp_err_r;
        end
    end

    // A reset on the entry edge must not let the pending write land.
    assign arr_wr_en_s = enter_resp_s && cur_req_s.we && !cur_err_s && !rst_i;
    assign arr_rd_en_s = enter_resp_s && !cur_req_s.we && !cur_err_s && !rst_i;
    assign arr_clr_s   = enter_resp_s && (cur_req_s.we || cur_err_s);

    // FSM, counter, latched request and registered handshake outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= IDLE;
            cnt_r       <= 4'd0;
            req_r       <= '0;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            cnt_r       <= cnt_next_s;
            req_r       <= req_next_s;
            req_ready_r <= (state_next_s == IDLE);
            rsp_valid_r <= rsp_valid_next_s;
            rsp_err_r   <= rsp_err_next_s;
        end
    end

    riscv_dmem_array #(
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_array (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .wr_en_i (arr_wr_en_s),
        .rd_en_i (arr_rd_en_s),
        .clr_i   (arr_clr_s),
        .addr_i  (cur_req_s.addr[IW+1:2]),
        .be_i    (cur_req_s.be),
        .wdata_i (cur_req_s.wdata),
        .rdata_o (arr_rdata_s)
    );

    assign rsp_s.rdata = arr_rdata_s;
    assign rsp_s.err   = rsp_err_r;

    assign req_ready_o = req_ready_r;
    assign rsp_valid_o = rsp_valid_r;
    assign rsp_rdata_o = rsp_s.rdata;
    assign rsp_err_o   = rsp_s.err;

endmodule

// File: tb/tb_riscv_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_riscv_dmem_responder
// Directed bench for riscv_dmem_responder. Three instances share the request
// payload and rsp_ready: index 0 has LATENCY=2, index 1 LATENCY=0, index 2
// LATENCY=4. Each has its own reset and req_valid.
// Latency is counted with the acceptance edge as edge 1, so a LATENCY=L
// build shows rsp_valid after edge L+1.
// -----------------------------------------------------------------------------
module tb_riscv_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rst;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [2:0]  rsp_valid;
    logic [2:0]  rsp_err;
    logic [31:0] rsp_rdata [3];
    logic        req_we;
    logic [31:0] req_addr;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic        rsp_ready;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        riscv_dmem_responder #(
            .DEPTH   (256),
            .LATENCY ((g == 0) ? 2 : ((g == 1) ? 0 : 4)),
            .AW      (32)
        ) u_dut (
            .clk_i       (clk),
            .rst_i       (rst[g]),
            .req_valid_i (req_valid[g]),
            .req_ready_o (req_ready[g]),
            .req_we_i    (req_we),
            .req_addr_i  (req_addr),
            .req_be_i    (req_be),
            .req_wdata_i (req_wdata),
            .rsp_valid_o (rsp_valid[g]),
            .rsp_ready_i (rsp_ready),
            .rsp_rdata_o (rsp_rdata[g]),
            .rsp_err_o   (rsp_err[g])
        );
    end

    // One full request/response with rsp_ready held high.
    task automatic transact(input int d, input logic we, input logic [31:0] addr,
                            input logic [3:0] be, input logic [31:0] wdata,
                            output logic [31:0] rdata, output logic err, output int lat);
        int guard;
        @(negedge clk);
        req_we = we; req_addr = addr; req_be = be; req_wdata = wdata;
        req_valid[d] = 1'b1;
        guard = 0;
        while (req_ready[d] !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        lat = 1;
        while (rsp_valid[d] !== 1'b1 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        rdata = rsp_rdata[d];
        err   = rsp_err[d];
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 3'b111; req_valid = 3'b000; rsp_ready = 1'b1;
        req_we = 1'b0; req_addr = 32'h0; req_be = 4'h0; req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            vec_cnt++; if (req_ready[d] !== 1'b1) begin miss_cnt++; $display("FAIL reset_ready[%0d]: got %b expected 1", d, req_ready[d]); end
            vec_cnt++; if (rsp_valid[d] !== 1'b0) begin miss_cnt++; $display("FAIL reset_valid[%0d]: got %b expected 0", d, rsp_valid[d]); end
            vec_cnt++; if (rsp_rdata[d] !== 32'h0) begin miss_cnt++; $display("FAIL reset_rdata[%0d]: got %h expected 0", d, rsp_rdata[d]); end
            vec_cnt++; if (rsp_err[d] !== 1'b0) begin miss_cnt++; $display("FAIL reset_err[%0d]: got %b expected 0", d, rsp_err[d]); end
        end
        @(negedge clk);
        rst = 3'b000;
    endtask

    task automatic test_write_read();
        logic [31:0] rd; logic er; int lat;
        transact(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, rd, er, lat);
        vec_cnt++; if (er !== 1'b0) begin miss_cnt++; $display("FAIL wr_err: got %b expected 0", er); end
        vec_cnt++; if (rd !== 32'h0) begin miss_cnt++; $display("FAIL wr_rdata: got %h expected 00000000", rd); end
        vec_cnt++; if (lat != 3) begin miss_cnt++; $display("FAIL wr_latency: got %0d expected 3", lat); end
        transact(0, 1'b0, 32'h10, 4'h0, 32'h0, rd, er, lat);
        vec_cnt++; if (er !== 1'b0) begin miss_cnt++; $display("FAIL rd_err: got %b expected 0", er); end
        vec_cnt++; if (rd !== 32'hDEADBEEF) begin miss_cnt++; $display("FAIL rd_rdata: got %h expected deadbeef", rd); end
        vec_cnt++; if (lat != 3) begin miss_cnt++; $display("FAIL rd_latency: got %0d expected 3", lat); end
    endtask

    task automatic test_byte_enables();
        logic [31:0] rd; logic er; int lat;
        transact(0, 1'b1, 32'h20, 4'hF, 32'h11223344, rd, er, lat);
        transact(0, 1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, rd, er, lat);
        vec_cnt++; if (er !== 1'b0) begin miss_cnt++; $display("FAIL be_wr_err: got %b expected 0", er); end
        transact(0, 1'b0, 32'h20, 4'h0, 32'h0, rd, er, lat);
        vec_cnt++; if (rd !== 32'h11BB33DD) begin miss_cnt++; $display("FAIL be_merge: got %h expected 11bb33dd", rd); end
        // be=0000 write leaves the word untouched
        transact(0, 1'b1, 32'h10, 4'h0, 32'h01234567, rd, er, lat);
        vec_cnt++; if (er !== 1'b0) begin miss_cnt++; $display("FAIL be0_err: got %b expected 0", er); end
        transact(0, 1'b0, 32'h10, 4'h0, 32'h0, rd, er, lat);
        vec_cnt++; if (rd !== 32'hDEADBEEF) begin miss_cnt++; $display("FAIL be0_unchanged: got %h expected deadbeef", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat;
        transact(0, 1'b0, 32'h13, 4'h0, 32'h0, rd, er, lat);
        vec_cnt++; if (er !== 1'b1) begin miss_cnt++; $display("FAIL misalign_err: got %b expected 1", er); end
        vec_cnt++; if (rd !== 32'h0) begin miss_cnt++; $display("FAIL misalign_rdata: got %h expected 00000000", rd); end
        transact(0, 1'b1, 32'h3FC, 4'hF, 32'hCAFEF00D, rd, er, lat);
        vec_cnt++; if (er !== 1'b0) begin miss_cnt++; $display("FAIL last_word_err: got %b expected 0", er); end
        transact(0, 1'b1, 32'h400, 4'hF, 32'hFFFFFFFF, rd, er, lat);
        vec_cnt++; if (er !== 1'b1) begin miss_cnt++; $display("FAIL range_err: got %b expected 1", er); end
        vec_cnt++; if (rd !== 32'h0) begin miss_cnt++; $display("FAIL range_rdata: got %h expected 00000000", rd); end
        transact(0, 1'b0, 32'h3FC, 4'h0, 32'h0, rd, er, lat);
        vec_cnt++; if (rd !== 32'hCAFEF00D) begin miss_cnt++; $display("FAIL range_nowrite: got %h expected cafef00d", rd); end
        vec_cnt++; if (er !== 1'b0) begin miss_cnt++; $display("FAIL last_word_rd_err: got %b expected 0", er); end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic er; int lat; int guard;
        rsp_ready = 1'b0;
        @(negedge clk);
        req_we = 1'b0; req_addr = 32'h20; req_be = 4'h0; req_wdata = 32'h0;
        req_valid[0] = 1'b1;
        @(posedge clk); #1;
        // keep a different request pending; it must be ignored until IDLE
        req_we = 1'b1; req_be = 4'hF; req_wdata = 32'h0BADCAFE;
        guard = 0;
        while (rsp_valid[0] !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        for (int c = 0; c < 5; c++) begin
            vec_cnt++; if (rsp_valid[0] !== 1'b1) begin miss_cnt++; $display("FAIL bp_valid[%0d]: got %b expected 1", c, rsp_valid[0]); end
            vec_cnt++; if (rsp_rdata[0] !== 32'h11BB33DD) begin miss_cnt++; $display("FAIL bp_rdata[%0d]: got %h expected 11bb33dd", c, rsp_rdata[0]); end
            vec_cnt++; if (rsp_err[0] !== 1'b0) begin miss_cnt++; $display("FAIL bp_err[%0d]: got %b expected 0", c, rsp_err[0]); end
            vec_cnt++; if (req_ready[0] !== 1'b0) begin miss_cnt++; $display("FAIL bp_ready[%0d]: got %b expected 0", c, req_ready[0]); end
            @(posedge clk); #1;
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        vec_cnt++; if (rsp_valid[0] !== 1'b0) begin miss_cnt++; $display("FAIL bp_drop: got %b expected 0", rsp_valid[0]); end
        vec_cnt++; if (req_ready[0] !== 1'b1) begin miss_cnt++; $display("FAIL bp_no_same_edge_accept: got %b expected 1", req_ready[0]); end
        @(posedge clk); #1;
        vec_cnt++; if (req_ready[0] !== 1'b0) begin miss_cnt++; $display("FAIL bp_next_accept: got %b expected 0", req_ready[0]); end
        req_valid[0] = 1'b0;
        guard = 0;
        while (rsp_valid[0] !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        @(posedge clk); #1;
        transact(0, 1'b0, 32'h20, 4'h0, 32'h0, rd, er, lat);
        vec_cnt++; if (rd !== 32'h0BADCAFE) begin miss_cnt++; $display("FAIL bp_pending_write: got %h expected 0badcafe", rd); end
    endtask

    task automatic test_latency0();
        logic [31:0] rd; logic er; int lat;
        transact(1, 1'b1, 32'h8, 4'hF, 32'h12345678, rd, er, lat);
        vec_cnt++; if (lat != 1) begin miss_cnt++; $display("FAIL l0_wr_latency: got %0d expected 1", lat); end
        transact(1, 1'b0, 32'h8, 4'h0, 32'h0, rd, er, lat);
        vec_cnt++; if (lat != 1) begin miss_cnt++; $display("FAIL l0_rd_latency: got %0d expected 1", lat); end
        vec_cnt++; if (rd !== 32'h12345678) begin miss_cnt++; $display("FAIL l0_rdata: got %h expected 12345678", rd); end
    endtask

    task automatic test_mid_reset();
        logic [31:0] rd; logic er; int lat; int seen; int guard;
        transact(2, 1'b1, 32'h40, 4'hF, 32'h55AA55AA, rd, er, lat);
        vec_cnt++; if (lat != 5) begin miss_cnt++; $display("FAIL l4_latency: got %0d expected 5", lat); end
        @(negedge clk);
        req_we = 1'b1; req_addr = 32'h40; req_be = 4'hF; req_wdata = 32'hFFFFFFFF;
        req_valid[2] = 1'b1;
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        @(negedge clk);
        rst[2] = 1'b1;
        @(posedge clk); #1;
        vec_cnt++; if (req_ready[2] !== 1'b1) begin miss_cnt++; $display("FAIL wait_rst_ready: got %b expected 1", req_ready[2]); end
        @(negedge clk);
        rst[2] = 1'b0;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (rsp_valid[2] === 1'b1) seen++;
        end
        vec_cnt++; if (seen != 0) begin miss_cnt++; $display("FAIL wait_rst_no_rsp: got %0d valid cycles expected 0", seen); end
        transact(2, 1'b0, 32'h40, 4'h0, 32'h0, rd, er, lat);
        vec_cnt++; if (rd !== 32'h55AA55AA) begin miss_cnt++; $display("FAIL wait_rst_no_write: got %h expected 55aa55aa", rd); end
        // reset landing in RESP drops the response
        rsp_ready = 1'b0;
        @(negedge clk);
        req_we = 1'b0; req_addr = 32'h10; req_be = 4'h0; req_wdata = 32'h0;
        req_valid[0] = 1'b1;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        guard = 0;
        while (rsp_valid[0] !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        vec_cnt++; if (rsp_rdata[0] !== 32'hDEADBEEF) begin miss_cnt++; $display("FAIL resp_rst_pre: got %h expected deadbeef", rsp_rdata[0]); end
        @(negedge clk);
        rst[0] = 1'b1;
        @(posedge clk); #1;
        vec_cnt++; if (rsp_valid[0] !== 1'b0) begin miss_cnt++; $display("FAIL resp_rst_valid: got %b expected 0", rsp_valid[0]); end
        vec_cnt++; if (rsp_rdata[0] !== 32'h0) begin miss_cnt++; $display("FAIL resp_rst_rdata: got %h expected 00000000", rsp_rdata[0]); end
        vec_cnt++; if (req_ready[0] !== 1'b1) begin miss_cnt++; $display("FAIL resp_rst_ready: got %b expected 1", req_ready[0]); end
        @(negedge clk);
        rst[0] = 1'b0;
        rsp_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_enables();
        test_errors();
        test_backpressure();
        test_latency0();
        test_mid_reset();
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
